// File: rtl/clock_logic_debounce_edge.sv
// Debounce/qualify a synchronized level, then publish a clean level, rise/fall
// pulses and a running count of accepted transitions.
module clock_logic_debounce_edge #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned COUNT_WIDTH   = 8,
    parameter bit          RESET_LEVEL   = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   data_in,
    input  logic                   enable,
    input  logic                   count_clear,
    output logic                   level_out,
    output logic                   rise_pulse,
    output logic                   fall_pulse,
    output logic [COUNT_WIDTH-1:0] edge_count,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        QUALIFY = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;
    logic [COUNT_WIDTH-1:0] edges_q, edges_d;
    logic                   commit;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
            edges_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
            edges_q <= edges_d;
        end
    end

    // Qualification: a change is accepted after STABLE_CYCLES consecutive differing samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        edges_d = edges_q;
        commit  = 1'b0;

        if (!enable || (data_in == level_q)) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (STABLE_CYCLES == 1) begin
                        commit = 1'b1;
                    end else begin
                        state_d = QUALIFY;
                        cnt_d   = CNT_W'(1);
                    end
                end
                QUALIFY: begin
                    if (CNT_W'(cnt_q + CNT_W'(1)) == CNT_W'(STABLE_CYCLES)) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Clear is applied before a same-edge increment.
        if (count_clear) begin
            edges_d = '0;
        end
        if (commit) begin
            level_d = ~level_q;
            rise_d  = ~level_q;
            fall_d  = level_q;
            edges_d = COUNT_WIDTH'(edges_d + COUNT_WIDTH'(1));
        end

        busy_d = (state_d == QUALIFY);
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = busy_q;
    assign edge_count = edges_q;

endmodule

// File: tb/tb_clock_logic_debounce_edge.sv
// Bench: three parameterisations of the debouncer on shared inputs, checked by
// directed scenarios and a random run against a run-length reference model.
module tb_clock_logic_debounce_edge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data = 1'b0;
    logic       en = 1'b1;
    logic       clr = 1'b0;
    logic [2:0] lvl, rise, fall, busy;
    logic [7:0] cnt0, cnt2;
    logic [1:0] cnt1;

    int errors = 0;
    int checks = 0;

    // Instance 0: SC=4 CW=8 RL=0; instance 1: SC=4 CW=2 RL=1; instance 2: SC=1 CW=8 RL=0
    int sc_a [3] = '{4, 4, 1};
    int mod_a[3] = '{256, 4, 256};
    bit rl_a [3] = '{1'b0, 1'b1, 1'b0};

    int m_run[3] = '{0, 0, 0};
    int m_cnt[3] = '{0, 0, 0};
    bit m_lvl[3] = '{1'b0, 1'b1, 1'b0};
    bit m_rise[3] = '{1'b0, 1'b0, 1'b0};
    bit m_fall[3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    clock_logic_debounce_edge #(.STABLE_CYCLES(4), .COUNT_WIDTH(8), .RESET_LEVEL(1'b0)) u_dut0 (
        .clock(clk), .reset(rst), .data_in(data), .enable(en), .count_clear(clr),
        .level_out(lvl[0]), .rise_pulse(rise[0]), .fall_pulse(fall[0]),
        .edge_count(cnt0), .busy(busy[0]));

    clock_logic_debounce_edge #(.STABLE_CYCLES(4), .COUNT_WIDTH(2), .RESET_LEVEL(1'b1)) u_dut1 (
        .clock(clk), .reset(rst), .data_in(data), .enable(en), .count_clear(clr),
        .level_out(lvl[1]), .rise_pulse(rise[1]), .fall_pulse(fall[1]),
        .edge_count(cnt1), .busy(busy[1]));

    clock_logic_debounce_edge #(.STABLE_CYCLES(1), .COUNT_WIDTH(8), .RESET_LEVEL(1'b0)) u_dut2 (
        .clock(clk), .reset(rst), .data_in(data), .enable(en), .count_clear(clr),
        .level_out(lvl[2]), .rise_pulse(rise[2]), .fall_pulse(fall[2]),
        .edge_count(cnt2), .busy(busy[2]));

    // Reference: count the run of enabled differing samples; accept when it reaches SC.
    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_lvl[i] = rl_a[i]; m_run[i] = 0; m_cnt[i] = 0;
                m_rise[i] = 1'b0; m_fall[i] = 1'b0;
            end else begin
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (clr) m_cnt[i] = 0;
                if (en && (data != m_lvl[i])) begin
                    m_run[i]++;
                    if (m_run[i] == sc_a[i]) begin
                        m_lvl[i]  = data;
                        m_rise[i] = data;
                        m_fall[i] = ~data;
                        m_cnt[i]  = (m_cnt[i] + 1) % mod_a[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [7:0] cnt_of(int i);
        return (i == 0) ? cnt0 : (i == 1) ? {6'b0, cnt1} : cnt2;
    endfunction

    task automatic test_reset();
        rst = 1'b1; data = 1'b0; en = 1'b1; clr = 1'b0;
        tick(); tick();
        checks++;
        if ({lvl, rise, fall, busy, cnt0, cnt1, cnt2} !== {3'b010, 3'b000, 3'b000, 3'b000, 8'd0, 2'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset: lvl=%b rise=%b fall=%b busy=%b cnt=%0d/%0d/%0d, want lvl=010 others 0",
                     lvl, rise, fall, busy, cnt0, cnt1, cnt2);
        end
    endtask

    task automatic test_accept_rise();
        data = 1'b1; rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (k < 3) begin
                if ({lvl[0], rise[0], fall[0], busy[0], cnt0} !== {4'b0001, 8'd0}) begin
                    errors++;
                    $display("FAIL accept_rise qualify k=%0d: got %b cnt=%0d want 0001 cnt=0", k,
                             {lvl[0], rise[0], fall[0], busy[0]}, cnt0);
                end
            end else if (k == 3) begin
                if ({lvl[0], rise[0], fall[0], busy[0], cnt0} !== {4'b1100, 8'd1}) begin
                    errors++;
                    $display("FAIL accept_rise commit: got %b cnt=%0d want 1100 cnt=1",
                             {lvl[0], rise[0], fall[0], busy[0]}, cnt0);
                end
            end else if ({lvl[0], rise[0], fall[0], busy[0], cnt0} !== {4'b1000, 8'd1}) begin
                errors++;
                $display("FAIL accept_rise after: got %b cnt=%0d want 1000 cnt=1",
                         {lvl[0], rise[0], fall[0], busy[0]}, cnt0);
            end
        end
    endtask

    task automatic test_accept_fall();
        data = 1'b0;
        for (int k = 0; k < 14; k++) begin
            logic [11:0] exp;
            tick();
            exp = (k < 3) ? {4'b1001, 8'd1} : (k == 3) ? {4'b0010, 8'd2} : {4'b0000, 8'd2};
            checks++;
            if ({lvl[0], rise[0], fall[0], busy[0], cnt0} !== exp) begin
                errors++;
                $display("FAIL accept_fall k=%0d: got %b cnt=%0d want %b cnt=%0d", k,
                         {lvl[0], rise[0], fall[0], busy[0]}, cnt0, exp[11:8], exp[7:0]);
            end
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 6; k++) begin
            logic [11:0] exp;
            data = (k < 3) ? 1'b1 : 1'b0;
            tick();
            exp = (k < 3) ? {4'b0001, 8'd2} : {4'b0000, 8'd2};
            checks++;
            if ({lvl[0], rise[0], fall[0], busy[0], cnt0} !== exp) begin
                errors++;
                $display("FAIL bounce k=%0d: got %b cnt=%0d want %b cnt=%0d", k,
                         {lvl[0], rise[0], fall[0], busy[0]}, cnt0, exp[11:8], exp[7:0]);
            end
        end
    endtask

    task automatic test_enable_reset();
        logic [11:0] exp [11];
        exp = '{{4'b0001, 8'd2}, {4'b0001, 8'd2}, {4'b0000, 8'd2},
                {4'b0001, 8'd2}, {4'b0001, 8'd2}, {4'b0001, 8'd2}, {4'b1100, 8'd3},
                {4'b1001, 8'd3}, {4'b1001, 8'd3}, {4'b0000, 8'd0}, {4'b0000, 8'd0}};
        for (int k = 0; k < 11; k++) begin
            data = (k < 7) ? 1'b1 : 1'b0;
            en   = (k != 2);
            rst  = (k == 9);
            tick();
            checks++;
            if ({lvl[0], rise[0], fall[0], busy[0], cnt0} !== exp[k]) begin
                errors++;
                $display("FAIL enable_reset k=%0d: got %b cnt=%0d want %b cnt=%0d", k,
                         {lvl[0], rise[0], fall[0], busy[0]}, cnt0, exp[k][11:8], exp[k][7:0]);
            end
        end
        rst = 1'b0; en = 1'b1;
    endtask

    task automatic test_wrap_clear();
        bit lv = 1'b1;
        int ec = 0;
        rst = 1'b1; data = 1'b1; tick(); rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            data = ~lv;
            for (int j = 0; j < 4; j++) begin
                clr = (k == 6 && j == 3);
                tick();
            end
            clr = 1'b0;
            lv = ~lv;
            ec = (k == 6) ? 1 : k % 4;
            checks++;
            if ({lvl[1], rise[1], fall[1], busy[1], cnt1} !== {lv, lv, ~lv, 1'b0, 2'(ec)}) begin
                errors++;
                $display("FAIL wrap k=%0d: got %b cnt=%0d want %b%b%b0 cnt=%0d", k,
                         {lvl[1], rise[1], fall[1], busy[1]}, cnt1, lv, lv, ~lv, ec);
            end
        end
        clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if ({lvl[1], rise[1], fall[1], busy[1], cnt1} !== {lv, 3'b000, 2'd0}) begin
            errors++;
            $display("FAIL clear_alone: got %b cnt=%0d want %b000 cnt=0",
                     {lvl[1], rise[1], fall[1], busy[1]}, cnt1, lv);
        end
    endtask

    task automatic test_single_cycle();
        bit prev = 1'b0;
        int ec = 0;
        rst = 1'b1; data = 1'b0; tick(); rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            bit d;
            d = 1'(k == 1 ? 1 : (k == 2 ? 0 : $urandom_range(0, 1)));
            data = d;
            tick();
            if (d != prev) ec++;
            checks++;
            if ({lvl[2], rise[2], fall[2], busy[2], cnt2} !== {d, d & ~prev, ~d & prev, 1'b0, 8'(ec)}) begin
                errors++;
                $display("FAIL single_cycle k=%0d: got %b cnt=%0d want %b%b%b0 cnt=%0d", k,
                         {lvl[2], rise[2], fall[2], busy[2]}, cnt2, d, d & ~prev, ~d & prev, ec);
            end
            prev = d;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) data = ~data;
            en  = ($urandom_range(0, 15) != 0);
            clr = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
            for (int i = 0; i < 3; i++) begin
                logic [11:0] got, exp;
                got = {lvl[i], rise[i], fall[i], busy[i], cnt_of(i)};
                exp = {m_lvl[i], m_rise[i], m_fall[i], (m_run[i] > 0), 8'(m_cnt[i])};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random k=%0d dut%0d: got %b cnt=%0d want %b cnt=%0d", k, i,
                             got[11:8], got[7:0], exp[11:8], exp[7:0]);
                end
            end
            checks++;
            if ((rise & fall) !== 3'b000) begin
                errors++;
                $display("FAIL random_exclusive k=%0d: rise=%b fall=%b want no overlap", k, rise, fall);
            end
        end
        rst = 1'b0; en = 1'b1; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_accept_rise();
        test_accept_fall();
        test_bounce();
        test_enable_reset();
        test_wrap_clear();
        test_single_cycle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
